rib_mem_arbiter: RTL and testbench

- Shares the single-ported simulation/on-chip RAM between three masters: debug module (JTAG, m0), core load/store unit (m1) and core instruction fetch (m2).
- Sits between tinyriscv_core's bus masters and the RAM.
- Grants at most one access per cycle and routes the read response back one cycle later.
- Raises a hold request to the core pipeline when a core master is stalled.

---
 rtl/rib_mem_arbiter_pkg.sv | 18 +
 rtl/rib_arb_rr2.sv | 33 +++
 rtl/rib_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_rib_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rib_mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: master indices, FSM states and
// default bus widths (RegBus / MemAddrBus are both 32 bits in tinyriscv).
package rib_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_NUM_M  = 3;

  localparam int ARB_M_DBG   = 0;
  localparam int ARB_M_DATA  = 1;
  localparam int ARB_M_FETCH = 2;

  typedef enum logic {
    ARB_RUN    = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rib_arb_rr2.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// pointer decides, and it moves to the other side after every taken grant.
// ptr = 0 prefers req[0], which is the reset choice.
module rib_arb_rr2
  import rib_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic ptr;

  // Pick a winner; only a tie consults the pointer
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // Advance the pointer only when the pick was actually used this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take && (|gnt)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/rib_mem_arbiter.sv
// Arbiter sharing the single-ported RAM between debug (m0), core data (m1)
// and core fetch (m2). Debug has fixed top priority and can lock the RAM.
// Build option RIB_ARB_RR_EN: round-robin between m1/m2 when defined,
// fixed priority m1 > m2 otherwise.
module rib_mem_arbiter
  import rib_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int NUM_M  = ARB_NUM_M
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_req,
  input  logic [NUM_M-1:0]        m_we,
  input  logic [NUM_M*4-1:0]      m_be,
  input  logic [NUM_M*ADDR_W-1:0] m_addr,
  input  logic [NUM_M*DATA_W-1:0] m_wdata,
  output logic [NUM_M-1:0]        m_gnt,
  output logic [NUM_M-1:0]        m_rvalid,
  output logic [DATA_W-1:0]       m_rdata,
  input  logic                    dbg_lock,
  output logic                    dbg_locked,
  output logic                    hold_flag_o,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  arb_state_e       state, state_next;
  logic [1:0]       core_gnt;
  logic [NUM_M-1:0] gnt;

`ifdef RIB_ARB_RR_EN
  logic core_take;

  // The core pick is consumed only when the RAM is ready, we are not
  // locked and debug is not taking the slot
  assign core_take = mem_ready && (state == ARB_RUN) && !m_req[ARB_M_DBG];

  rib_arb_rr2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (m_req[ARB_M_FETCH:ARB_M_DATA]),
    .take (core_take),
    .gnt  (core_gnt)
  );
`else
  // Fixed priority between the core masters: data beats fetch
  always_comb begin
    core_gnt = 2'b00;
    if (m_req[ARB_M_DATA]) begin
      core_gnt = 2'b01;
    end else if (m_req[ARB_M_FETCH]) begin
      core_gnt = 2'b10;
    end
  end
`endif

  // Lock FSM next state and the one-hot grant for this cycle
  always_comb begin
    state_next = state;
    gnt        = '0;
    case (state)
      ARB_RUN:    if (dbg_lock)  state_next = ARB_LOCKED;
      ARB_LOCKED: if (!dbg_lock) state_next = ARB_RUN;
    endcase
    if (mem_ready) begin
      if (m_req[ARB_M_DBG]) begin
        gnt[ARB_M_DBG] = 1'b1;
      end else if (state == ARB_RUN) begin
        gnt[ARB_M_FETCH:ARB_M_DATA] = core_gnt;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Registered lock status and read-valid; a reset drops any pending read
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_locked <= 1'b0;
      m_rvalid   <= '0;
    end else begin
      dbg_locked <= (state_next == ARB_LOCKED);
      m_rvalid   <= gnt & ~m_we;
    end
  end

  // Route the granted master onto the RAM port; all zero when idle
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt[i]) begin
        mem_we    = m_we[i];
        mem_be    = m_be[4*i +: 4];
        mem_addr  = m_addr[ADDR_W*i +: ADDR_W];
        mem_wdata = m_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign m_gnt       = gnt;
  assign mem_req     = |gnt;
  assign m_rdata     = (|m_rvalid) ? mem_rdata : '0;
  assign hold_flag_o = (m_req[ARB_M_DATA]  & ~gnt[ARB_M_DATA]) |
                       (m_req[ARB_M_FETCH] & ~gnt[ARB_M_FETCH]);

endmodule

// File: tb/tb_rib_mem_arbiter.sv
// Self-checking bench for rib_mem_arbiter: per-cycle vector table plus a
// read-data scoreboard. Expectations follow the RIB_ARB_RR_EN setting.
module tb_rib_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  m_req;
  logic [2:0]  m_we;
  logic [11:0] m_be;
  logic [95:0] m_addr;
  logic [95:0] m_wdata;
  logic [2:0]  m_gnt;
  logic [2:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic        dbg_lock;
  logic        dbg_locked;
  logic        hold_flag_o;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        lock;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] a1;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic        hold;
    logic        locked;
    bit          nopush;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] d;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [31:0] ram[1024];
  logic [31:0] ref_mem[1024];
  int          checks;
  int          errors;

  localparam logic [31:0] A0 = 32'h40;
  localparam logic [31:0] A2 = 32'h200;
  localparam logic [31:0] D0 = 32'hDEADBEEF;

  rib_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_be        (m_be),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_gnt       (m_gnt),
    .m_rvalid    (m_rvalid),
    .m_rdata     (m_rdata),
    .dbg_lock    (dbg_lock),
    .dbg_locked  (dbg_locked),
    .hold_flag_o (hold_flag_o),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-enabled writes, reads return data on the next cycle
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr[11:2]];
      end
    end
  end

  function automatic vec_t mk(logic r, logic rdy, logic lk, logic [2:0] req,
                              logic [2:0] we, logic [31:0] a1, logic [2:0] gnt,
                              logic [2:0] rv, logic hold, logic locked, bit np);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.lock = lk; v.req = req; v.we = we; v.a1 = a1;
    v.gnt = gnt; v.rv = rv; v.hold = hold; v.locked = locked; v.nopush = np;
    return v;
  endfunction

  function automatic logic [31:0] addrOf(int i, logic [31:0] a1);
    return (i == 0) ? A0 : (i == 1) ? a1 : A2;
  endfunction

  task automatic check(string name, int n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL v%0d %s: got %h want %h", n, name, got, want);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    logic [31:0] a;
    rst       = v.rst;
    mem_ready = v.rdy;
    dbg_lock  = v.lock;
    m_req     = v.req;
    m_we      = v.we;
    m_be      = 12'hFFF;
    m_addr    = {A2, v.a1, A0};
    m_wdata   = {32'h22222222, 32'h11111111, D0};
    for (int i = 0; i < 3; i++) begin
      if (v.gnt[i]) begin
        a = addrOf(i, v.a1);
        if (v.we[i]) begin
          ref_mem[a[11:2]] = m_wdata[32*i +: 32];
        end else if (!v.nopush) begin
          sb.push_back('{m: i, d: ref_mem[a[11:2]]});
        end
      end
    end
  endtask

  task automatic checkOutput(int n, vec_t v);
    sb_t e;
    check("gnt", n, {29'b0, m_gnt}, {29'b0, v.gnt});
    check("rvalid", n, {29'b0, m_rvalid}, {29'b0, v.rv});
    check("hold", n, {31'b0, hold_flag_o}, {31'b0, v.hold});
    check("dbg_locked", n, {31'b0, dbg_locked}, {31'b0, v.locked});
    check("mem_req", n, {31'b0, mem_req}, {31'b0, |v.gnt});
    for (int i = 0; i < 3; i++) begin
      if (v.gnt[i]) begin
        check("mem_addr", n, mem_addr, addrOf(i, v.a1));
        check("mem_we", n, {31'b0, mem_we}, {31'b0, v.we[i]});
      end
    end
    if (|m_rvalid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", n, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rvalid_master", n, {29'b0, m_rvalid}, 32'd1 << e.m);
        check("rdata", n, m_rdata, e.d);
      end
    end else begin
      check("rdata_idle", n, m_rdata, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'hA5000000 | (i << 2);
      ref_mem[i] = 32'hA5000000 | (i << 2);
    end
    mem_rdata = 32'h0;
    rst = 1'b1; mem_ready = 1'b1; dbg_lock = 1'b0;
    m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;

    // Reset and two-master read
    vecs.push_back(mk(1,1,0,3'b000,3'b000,32'h100,3'b000,3'b000,0,0,0));
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b010,3'b000,1,0,0));
    vecs.push_back(mk(0,1,0,3'b100,3'b000,32'h100,3'b100,3'b010,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h100,3'b000,3'b100,0,0,0));
    // Debug write beats both core masters, then read-back via m1
    vecs.push_back(mk(0,1,0,3'b111,3'b001,32'h100,3'b001,3'b000,1,0,0));
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b010,3'b000,1,0,0));
    vecs.push_back(mk(0,1,0,3'b100,3'b000,32'h100,3'b100,3'b010,0,0,0));
    vecs.push_back(mk(0,1,0,3'b010,3'b000,32'h040,3'b010,3'b100,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h040,3'b000,3'b010,0,0,0));
    // RAM not ready for three cycles
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,0,3'b110,3'b000,32'h104,3'b000,3'b000,1,0,0));
`ifdef RIB_ARB_RR_EN
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h104,3'b100,3'b000,1,0,0));
    vecs.push_back(mk(0,1,0,3'b010,3'b000,32'h104,3'b010,3'b100,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h104,3'b000,3'b010,0,0,0));
    // Continuous contention alternates
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b100,3'b000,1,0,0));
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b010,3'b100,1,0,0));
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b100,3'b010,1,0,0));
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b010,3'b100,1,0,0));
`else
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h104,3'b010,3'b000,1,0,0));
    vecs.push_back(mk(0,1,0,3'b100,3'b000,32'h104,3'b100,3'b010,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h104,3'b000,3'b100,0,0,0));
    // Continuous contention starves fetch
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b010,3'b000,1,0,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b010,3'b010,1,0,0));
`endif
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h100,3'b000,3'b010,0,0,0));
    // Debug lock while fetch reads continuously
    vecs.push_back(mk(0,1,1,3'b100,3'b000,32'h100,3'b100,3'b000,0,0,0));
    vecs.push_back(mk(0,1,1,3'b100,3'b000,32'h100,3'b000,3'b100,1,1,0));
    vecs.push_back(mk(0,1,1,3'b101,3'b001,32'h100,3'b001,3'b000,1,1,0));
    vecs.push_back(mk(0,1,1,3'b101,3'b000,32'h100,3'b001,3'b000,1,1,0));
    vecs.push_back(mk(0,1,0,3'b100,3'b000,32'h100,3'b000,3'b001,1,1,0));
    vecs.push_back(mk(0,1,0,3'b100,3'b000,32'h100,3'b100,3'b000,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h100,3'b000,3'b100,0,0,0));
    // Reset hits at the edge after an m1 read grant (lock also requested)
    vecs.push_back(mk(1,1,1,3'b010,3'b000,32'h100,3'b010,3'b000,0,0,1));
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h100,3'b000,3'b000,0,0,0));
    vecs.push_back(mk(0,1,0,3'b110,3'b000,32'h100,3'b010,3'b000,1,0,0));
    vecs.push_back(mk(0,1,0,3'b100,3'b000,32'h100,3'b100,3'b010,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000,3'b000,32'h100,3'b000,3'b100,0,0,0));

    repeat (2) @(posedge clk);
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      applyStimulus(vecs[n]);
      #1;
      checkOutput(n, vecs[n]);
    end
    check("sb_drained", vecs.size(), sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
